// File: rtl/nsc_pkg.sv
// rtl/nsc_pkg.sv - shared opcodes and sequencer constants for the NSC accumulator core
//
// Purpose: opcode encodings (upper four instruction bits), T-state bit
// indices into the one-hot ring, and the ring width.
// Ports: none (package).
package nsc_pkg;

  localparam int RING_W = 5;

  // Bit positions of each T-state inside the one-hot ring.
  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDI = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JC  = 4'd6;
  localparam logic [3:0] OP_JZ  = 4'd7;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

endpackage

// File: rtl/nsc_ring_counter.sv
// rtl/nsc_ring_counter.sv - one-hot T-state ring with early wrap, hold and clear
//
// Purpose: sequences T0..T4 for the accumulator core. One bit is set at a time.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (ring -> T0)
//   wrap         : return to T0 on the next edge (instruction finished early)
//   hold         : keep the current T-state
//   clr          : force T0; beats hold and wrap
//   ring         : one-hot T-state
module nsc_ring_counter
  import nsc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wrap,
  input  logic              hold,
  input  logic              clr,
  output logic [RING_W-1:0] ring
);

  localparam logic [RING_W-1:0] RING_T0 = RING_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ring <= RING_T0;
    end else if (clr) begin
      ring <= RING_T0;
    end else if (hold) begin
      ring <= ring;
    end else if (wrap) begin
      ring <= RING_T0;
    end else begin
      // Natural rotation also brings T4 back to T0.
      ring <= {ring[RING_W-2:0], ring[RING_W-1]};
    end
  end

endmodule

// File: rtl/nsc_cpu.sv
// rtl/nsc_cpu.sv - parametrised NSC accumulator CPU with internal RAM and load port
//
// Purpose: fetch/execute accumulator machine sequenced by a one-hot ring.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   prog_en         : load mode; suspends execution, holds PC/ring at 0/T0
//   prog_we         : RAM write strobe, honoured only while prog_en is high
//   prog_addr       : RAM load address (A bits)
//   prog_data       : RAM load data (N bits)
//   output_contents : OUT register
//   out_valid       : one-cycle pulse after the OUT register updates
//   halted          : set by HLT
//   ring_state      : one-hot T-state for debug
module nsc_cpu
  import nsc_pkg::*;
#(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [A-1:0]      prog_addr,
  input  logic [N-1:0]      prog_data,
  output logic [N-1:0]      output_contents,
  output logic              out_valid,
  output logic              halted,
  output logic [RING_W-1:0] ring_state
);

  logic [N-1:0] ram [2**A];

  logic [A-1:0] pc;
  logic [A-1:0] mar;
  logic [N-1:0] ir;
  logic [N-1:0] areg;
  logic [N-1:0] breg;
  logic         c_flag;
  logic         z_flag;

  logic [3:0]   opcode;
  logic [A-1:0] opnd;
  logic [N-1:0] ldi_val;
  logic [N-1:0] ram_rd;
  logic         is_sub;
  logic [N-1:0] b_op;
  logic [N:0]   sum;

  logic wrap;
  logic hold;
  logic clr;

  assign opcode  = ir[N-1:N-4];
  assign opnd    = ir[A-1:0];
  assign ldi_val = {4'b0000, ir[N-5:0]};
  assign ram_rd  = ram[mar];

  // Subtraction as A + ~B + 1 so the carry out directly means "no borrow".
  assign is_sub = (opcode == OP_SUB);
  assign b_op   = is_sub ? ~breg : breg;
  assign sum    = {1'b0, areg} + {1'b0, b_op} + {{N{1'b0}}, is_sub};

  nsc_ring_counter u_ring (
    .clk     (clk),
    .reset_n (reset_n),
    .wrap    (wrap),
    .hold    (hold),
    .clr     (clr),
    .ring    (ring_state)
  );

  // Decode: pick the last T-state of each instruction; HLT parks the ring at T2.
  always_comb begin
    wrap = 1'b0;
    hold = 1'b0;
    clr  = prog_en;
    if (!prog_en) begin
      if (ring_state[T2]) begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: wrap = 1'b0;
          OP_HLT:                         hold = 1'b1;
          default:                        wrap = 1'b1;
        endcase
      end
      if (ring_state[T3] && (opcode == OP_LDA || opcode == OP_STA)) begin
        wrap = 1'b1;
      end
      if (ring_state[T4]) begin
        wrap = 1'b1;
      end
    end
  end

  // RAM has no reset. The load port owns it during load mode, so an STA cut
  // short by prog_en never writes.
  always_ff @(posedge clk) begin
    if (prog_en) begin
      if (prog_we) begin
        ram[prog_addr] <= prog_data;
      end
    end else if (ring_state[T3] && opcode == OP_STA) begin
      ram[mar] <= areg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc              <= '0;
      mar             <= '0;
      ir              <= '0;
      areg            <= '0;
      breg            <= '0;
      c_flag          <= 1'b0;
      z_flag          <= 1'b0;
      output_contents <= '0;
      out_valid       <= 1'b0;
      halted          <= 1'b0;
    end else if (prog_en) begin
      pc        <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (ring_state[T0]) begin
        mar <= pc;
      end
      if (ring_state[T1]) begin
        ir <= ram_rd;
        pc <= pc + A'(1);
      end
      if (ring_state[T2]) begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= opnd;
          OP_LDI: areg <= ldi_val;
          OP_JMP: pc <= opnd;
          OP_JC:  if (c_flag) pc <= opnd;
          OP_JZ:  if (z_flag) pc <= opnd;
          OP_OUT: begin
            output_contents <= areg;
            out_valid       <= 1'b1;
          end
          OP_HLT: halted <= 1'b1;
          default: ;
        endcase
      end
      if (ring_state[T3]) begin
        case (opcode)
          OP_LDA:         areg <= ram_rd;
          OP_ADD, OP_SUB: breg <= ram_rd;
          default: ;
        endcase
      end
      if (ring_state[T4] && (opcode == OP_ADD || opcode == OP_SUB)) begin
        areg   <= sum[N-1:0];
        c_flag <= sum[N];
        z_flag <= (sum[N-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_nsc_cpu.sv
// tb/tb_nsc_cpu.sv - self-checking bench for nsc_cpu against an instruction-level model
module tb_nsc_cpu;

  logic       clk;
  logic       reset_n;
  logic       prog_en;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] output_contents;
  logic       out_valid;
  logic       halted;
  logic [4:0] ring_state;

  nsc_cpu #(.N(8), .A(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .prog_en         (prog_en),
    .prog_we         (prog_we),
    .prog_addr       (prog_addr),
    .prog_data       (prog_data),
    .output_contents (output_contents),
    .out_valid       (out_valid),
    .halted          (halted),
    .ring_state      (ring_state)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int obs_pulses;

  logic [7:0] mem [16];

  logic [4:0] exp_ring  [256];
  logic       exp_valid [256];
  logic       exp_halt  [256];
  logic [7:0] exp_oc    [256];
  logic [7:0] m_a;
  logic       m_c;
  logic       m_z;
  logic       m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Instruction-level model: runs whole instructions, then spreads each one
  // over its cycle count to get the per-cycle view of the visible outputs.
  task automatic model(input int hz);
    logic [7:0] m [16];
    logic [3:0] pc;
    logic [3:0] op;
    logic [3:0] ad;
    logic [7:0] ir;
    logic [7:0] b;
    logic [7:0] a;
    logic [7:0] oc;
    logic       c;
    logic       z;
    int t;
    int lat;
    m = mem;
    pc = 0; a = 0; c = 0; z = 0; oc = 0; t = 0; m_halt = 0;
    for (int k = 0; k < 256; k++) begin
      exp_ring[k] = 0; exp_valid[k] = 0; exp_halt[k] = 0; exp_oc[k] = 0;
    end
    while (t < hz && !m_halt) begin
      ir = m[pc];
      pc = pc + 4'd1;
      op = ir[7:4];
      ad = ir[3:0];
      lat = 3;
      case (op)
        4'd0:  begin a = m[ad]; lat = 4; end
        4'd1:  begin b = m[ad]; c = (int'(a) + int'(b)) > 255; a = a + b; z = (a == 0); lat = 5; end
        4'd2:  begin b = m[ad]; c = (a >= b); a = a - b; z = (a == 0); lat = 5; end
        4'd3:  begin m[ad] = a; lat = 4; end
        4'd4:  a = {4'd0, ad};
        4'd5:  pc = ad;
        4'd6:  if (c) pc = ad;
        4'd7:  if (z) pc = ad;
        4'd15: m_halt = 1;
        default: ;
      endcase
      for (int k = 0; k < lat && t + k < 256; k++) begin
        exp_ring[t+k] = 5'(1 << k);
        exp_oc[t+k]   = oc;
      end
      if (op == 4'd14) begin
        oc = a;
        if (t + 3 < 256) exp_valid[t+3] = 1;
      end
      if (m_halt) begin
        for (int k = t + 3; k < 256; k++) begin
          exp_ring[k] = 5'b00100; exp_halt[k] = 1; exp_oc[k] = oc;
        end
      end
      t += lat;
    end
    m_a = a; m_c = c; m_z = z;
  endtask

  task automatic do_reset();
    prog_en = 1;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  // Ends on a negedge with prog_en still high; the edge that wrote the last
  // word is the last one that samples load mode.
  task automatic load_prog();
    @(negedge clk);
    prog_en = 1;
    prog_we = 1;
    for (int i = 0; i < 16; i++) begin
      prog_addr = 4'(i);
      prog_data = mem[i];
      @(negedge clk);
      if (i == 0) begin
        check("load_ring", ring_state, 5'b00001);
        check("load_halted", halted, 0);
        check("load_valid", out_valid, 0);
      end
    end
    prog_we = 0;
  endtask

  task automatic run_prog(input int hz);
    model(hz);
    load_prog();
    prog_en = 0;
    obs_pulses = 0;
    for (int k = 0; k < hz; k++) begin
      if (k > 0) @(negedge clk);
      check("ring", ring_state, exp_ring[k]);
      check("out_valid", out_valid, exp_valid[k]);
      check("halted", halted, exp_halt[k]);
      check("output", output_contents, exp_oc[k]);
      if (out_valid) obs_pulses++;
      // Writes while not in load mode must be ignored.
      prog_we   = 1'($urandom);
      prog_addr = 4'($urandom);
      prog_data = 8'($urandom);
    end
    prog_we = 0;
    if (m_halt) begin
      check("areg", dut.areg, m_a);
      check("c_flag", dut.c_flag, m_c);
      check("z_flag", dut.z_flag, m_z);
    end
  endtask

  initial begin
    clk = 0; reset_n = 0; prog_en = 1; prog_we = 0; prog_addr = 0; prog_data = 0;
    n_cmp = 0; n_bad = 0; obs_pulses = 0;

    @(negedge clk);
    check("rst_ring", ring_state, 5'b00001);
    check("rst_out", output_contents, 0);
    check("rst_valid", out_valid, 0);
    check("rst_halted", halted, 0);

    // 1: LDI 5; ADD 15; OUT; HLT with RAM[15]=3
    do_reset();
    mem = '{default: 8'h00};
    mem[0] = 8'h45; mem[1] = 8'h1F; mem[2] = 8'hE0; mem[3] = 8'hF0; mem[15] = 8'd3;
    run_prog(40);
    check("t1_out", output_contents, 8);
    check("t1_pulses", obs_pulses, 1);
    check("t1_ring", ring_state, 5'b00100);

    // 2: carry-taken JC skips the OUT of 44
    do_reset();
    mem = '{default: 8'h00};
    mem[0] = 8'h0E; mem[1] = 8'h1F; mem[2] = 8'h66; mem[3] = 8'hE0; mem[4] = 8'hF0;
    mem[6] = 8'h49; mem[7] = 8'hE0; mem[8] = 8'hF0; mem[14] = 8'd200; mem[15] = 8'd100;
    run_prog(40);
    check("t2_out", output_contents, 9);
    check("t2_pulses", obs_pulses, 1);

    // 3: SUB to zero sets Z and C; JZ taken
    do_reset();
    mem = '{default: 8'h00};
    mem[0] = 8'h45; mem[1] = 8'h3D; mem[2] = 8'h2D; mem[3] = 8'h75; mem[4] = 8'hF0;
    mem[5] = 8'h41; mem[6] = 8'hE0; mem[7] = 8'hF0;
    run_prog(50);
    check("t3_out", output_contents, 1);
    check("t3_z", dut.z_flag, 1);
    check("t3_c", dut.c_flag, 1);

    // 4: PC wraps 15 -> 0 into an OUT planted by STA (self-modifying)
    do_reset();
    mem = '{default: 8'h00};
    mem[0] = 8'h5D; mem[1] = 8'hF0; mem[12] = 8'hE0; mem[13] = 8'h0C;
    mem[14] = 8'h30; mem[15] = 8'h47;
    run_prog(50);
    check("t4_out", output_contents, 7);
    check("t4_pulses", obs_pulses, 1);

    // Random programs, including jumps, loops and self-modification.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      run_prog(200);
    end

    // 5: abort ADD at T3, then asynchronous reset mid-run
    do_reset();
    mem = '{default: 8'h00};
    mem[0] = 8'h45; mem[1] = 8'hE0; mem[2] = 8'h1F; mem[3] = 8'hE0; mem[4] = 8'hF0;
    mem[15] = 8'hFF;
    load_prog();
    prog_en = 0;
    repeat (9) @(negedge clk);
    check("t5_at_t3", ring_state, 5'b01000);
    prog_en = 1;
    repeat (3) @(negedge clk);
    check("t5_abort_ring", ring_state, 5'b00001);
    check("t5_abort_areg", dut.areg, 5);
    check("t5_abort_c", dut.c_flag, 0);
    check("t5_abort_z", dut.z_flag, 0);
    check("t5_abort_out", output_contents, 5);
    check("t5_abort_valid", out_valid, 0);
    prog_en = 0;
    repeat (20) @(negedge clk);
    check("t5_halted", halted, 1);
    check("t5_out", output_contents, 4);
    check("t5_c", dut.c_flag, 1);
    @(posedge clk);
    #2;
    reset_n = 0;
    #1;
    check("t5_rst_ring", ring_state, 5'b00001);
    check("t5_rst_out", output_contents, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_halted", halted, 0);
    @(negedge clk);
    reset_n = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
